param_tx_pingpong_ram: RTL

//  Double-buffered parameter TX frame store. Generalises our dual-port TX RAM.
//  The host (Avalon-MM s1) fills a shadow bank while the serial transmitter (s2) reads the active bank.
//  A host commit swaps the banks only when the transmitter has finished its current frame.

---
 rtl/param_tx_pkg.sv | 24 ++
 rtl/param_tx_dp_bank_ram.sv | 113 +++++++++++
 rtl/param_tx_pingpong_ram.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/param_tx_pkg.sv
// ============================================================================
//  Module      : param_tx_pkg
//  Description : Shared constants for the parameter TX ping-pong frame store:
//                bank count and commit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_tx_pkg;

    // Two physical banks: one active (transmitter), one shadow (host)
    localparam int BANKS = 2;

    // Commit FSM state encoding
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PENDING = 2'd1;
    localparam state_t ST_SWAP    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/param_tx_dp_bank_ram.sv
// ============================================================================
//  Module      : param_tx_dp_bank_ram
//  Description : Inferred true-dual-port RAM holding both frame banks
//                (DATA_W x BANKS*2**ADDR_W). Port A is byte-enabled
//                read/write, port B is read-only. Macro
//                PARAM_TX_RAM_OUTREG_EN adds an output register stage on
//                both read ports (read latency 2 instead of 1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_tx_dp_bank_ram
    import param_tx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    // Port A: host side, byte-enabled read/write
    input  logic [ADDR_W:0]       i_a_addr,
    input  logic                  i_a_we,
    input  logic                  i_a_re,
    input  logic [DATA_W/8-1:0]   i_a_be,
    input  logic [DATA_W-1:0]     i_a_wdata,
    output logic [DATA_W-1:0]     o_a_rdata,
    output logic                  o_a_rvalid,
    // Port B: transmitter side, read-only
    input  logic [ADDR_W:0]       i_b_addr,
    input  logic                  i_b_re,
    output logic [DATA_W-1:0]     o_b_rdata,
    output logic                  o_b_rvalid
);

    localparam int c_BE_W  = DATA_W / 8;
    localparam int c_WORDS = BANKS * (2 ** ADDR_W);

    logic [DATA_W-1:0] r_mem [c_WORDS];

    logic [DATA_W-1:0] r_a_q;
    logic [DATA_W-1:0] r_b_q;
    logic              r_a_v;
    logic              r_b_v;

    // Byte-lane writes from port A; a write with no lanes enabled changes nothing
    always_ff @(posedge clk) begin
        if (i_a_we) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (i_a_be[b]) begin
                    r_mem[i_a_addr][b*8 +: 8] <= i_a_wdata[b*8 +: 8];
                end
            end
        end
    end

    // First read stage on both ports; data holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_q <= '0;
            r_b_q <= '0;
            r_a_v <= 1'b0;
            r_b_v <= 1'b0;
        end else begin
            r_a_v <= i_a_re;
            r_b_v <= i_b_re;
            if (i_a_re) begin
                r_a_q <= r_mem[i_a_addr];
            end
            if (i_b_re) begin
                r_b_q <= r_mem[i_b_addr];
            end
        end
    end

`ifdef PARAM_TX_RAM_OUTREG_EN
    logic [DATA_W-1:0] r_a_q2;
    logic [DATA_W-1:0] r_b_q2;
    logic              r_a_v2;
    logic              r_b_v2;

    // Optional output stage: data and valid both delayed one more clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_q2 <= '0;
            r_b_q2 <= '0;
            r_a_v2 <= 1'b0;
            r_b_v2 <= 1'b0;
        end else begin
            r_a_v2 <= r_a_v;
            r_b_v2 <= r_b_v;
            if (r_a_v) begin
                r_a_q2 <= r_a_q;
            end
            if (r_b_v) begin
                r_b_q2 <= r_b_q;
            end
        end
    end

    assign o_a_rdata  = r_a_q2;
    assign o_a_rvalid = r_a_v2;
    assign o_b_rdata  = r_b_q2;
    assign o_b_rvalid = r_b_v2;
`else
    assign o_a_rdata  = r_a_q;
    assign o_a_rvalid = r_a_v;
    assign o_b_rdata  = r_b_q;
    assign o_b_rvalid = r_b_v;
`endif

endmodule

`default_nettype wire

// File: rtl/param_tx_pingpong_ram.sv
// ============================================================================
//  Module      : param_tx_pingpong_ram
//  Description : Double-buffered parameter TX frame store. The host fills
//                the shadow bank over s1 while the transmitter reads the
//                active bank over s2. A commit swaps banks once the
//                transmitter has finished its current frame.
//                Macro PARAM_TX_RAM_OUTREG_EN: read latency 2 on s1/s2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_tx_pingpong_ram
    import param_tx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    // Host port (shadow bank)
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_write,
    input  logic                  s1_read,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    // Transmitter port (active bank)
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_read,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    // Commit handshake
    input  logic                  commit_req,
    input  logic [LEN_W-1:0]      commit_len,
    output logic                  commit_busy,
    output logic                  commit_ack,
    output logic                  commit_ovf,
    input  logic                  ovf_clr,
    // Frame status towards the transmitter
    output logic                  tx_frame_valid,
    output logic [LEN_W-1:0]      tx_frame_len,
    input  logic                  tx_frame_done,
    output logic                  active_bank
);

    localparam int             c_DEPTH     = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] c_DEPTH_LEN = LEN_W'(c_DEPTH);

    state_t           r_state;
    logic [LEN_W-1:0] r_pend_len;
    logic             r_active_bank;
    logic             r_tx_valid;
    logic [LEN_W-1:0] r_tx_len;
    logic             r_ack;
    logic             r_ovf;

    logic             w_len_clip;
    logic [LEN_W-1:0] w_len_sat;
    logic             w_ovf_set;
    logic             w_s1_we;
    logic             w_s1_re;

    // A frame can never exceed one bank; longer requests are clipped and flagged
    assign w_len_clip = (commit_len > c_DEPTH_LEN);
    assign w_len_sat  = w_len_clip ? c_DEPTH_LEN : commit_len;

    // Overflow on a clipped length, or on any request while a commit is in flight
    assign w_ovf_set  = commit_req &
                        ((r_state != ST_IDLE) | w_len_clip);

    assign w_s1_we    = s1_chipselect & s1_write;
    assign w_s1_re    = s1_chipselect & s1_read;

    // Commit FSM: wait for the transmitter to release the active bank, then swap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pend_len <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (commit_req) begin
                        r_pend_len <= w_len_sat;
                        r_state    <= r_tx_valid ? ST_PENDING : ST_SWAP;
                    end
                end
                ST_PENDING: begin
                    if (tx_frame_done || !r_tx_valid) begin
                        r_state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bank swap and frame status; a swap overrides a same-cycle done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active_bank <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_len      <= '0;
            r_ack         <= 1'b0;
        end else begin
            r_ack <= (r_state == ST_SWAP);
            if (r_state == ST_SWAP) begin
                r_active_bank <= ~r_active_bank;
                r_tx_len      <= r_pend_len;
                r_tx_valid    <= 1'b1;
            end else if (tx_frame_done && r_tx_valid) begin
                r_tx_valid    <= 1'b0;
            end
        end
    end

    // Sticky overflow flag; clear wins over a same-cycle set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end
    end

    // Bank steering uses the bank select held at the start of the cycle, so a
    // host write in the swap cycle lands in the bank about to become active
    param_tx_dp_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .i_a_addr   ({~r_active_bank, s1_address}),
        .i_a_we     (w_s1_we),
        .i_a_re     (w_s1_re),
        .i_a_be     (s1_byteenable),
        .i_a_wdata  (s1_writedata),
        .o_a_rdata  (s1_readdata),
        .o_a_rvalid (s1_readdatavalid),
        .i_b_addr   ({r_active_bank, s2_address}),
        .i_b_re     (s2_read),
        .o_b_rdata  (s2_readdata),
        .o_b_rvalid (s2_readdatavalid)
    );

    assign commit_busy    = (r_state != ST_IDLE);
    assign commit_ack     = r_ack;
    assign commit_ovf     = r_ovf;
    assign tx_frame_valid = r_tx_valid;
    assign tx_frame_len   = r_tx_len;
    assign active_bank    = r_active_bank;

endmodule

`default_nettype wire
